// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one transaction at a time onto a 1-cycle-latency single-port SRAM macro.
// Define AXI_SLAVE_DECERR_EN to reject addresses above the SRAM with DECERR (default: upper bits alias).
module axi_sram_slave #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   ARID_S,
   input  logic [ADDR_W-1:0] ARADDR_S,
   input  logic [3:0]        ARLEN_S,
   input  logic [2:0]        ARSIZE_S,
   input  logic [1:0]        ARBURST_S,
   input  logic              ARVALID_S,
   output logic              ARREADY_S,
   output logic [ID_W-1:0]   RID_S,
   output logic [DATA_W-1:0] RDATA_S,
   output logic [1:0]        RRESP_S,
   output logic              RLAST_S,
   output logic              RVALID_S,
   input  logic              RREADY_S,
   input  logic [ID_W-1:0]   AWID_S,
   input  logic [ADDR_W-1:0] AWADDR_S,
   input  logic [3:0]        AWLEN_S,
   input  logic [2:0]        AWSIZE_S,
   input  logic [1:0]        AWBURST_S,
   input  logic              AWVALID_S,
   output logic              AWREADY_S,
   input  logic [DATA_W-1:0] WDATA_S,
   input  logic [3:0]        WSTRB_S,
   input  logic              WLAST_S,
   input  logic              WVALID_S,
   output logic              WREADY_S,
   output logic [ID_W-1:0]   BID_S,
   output logic [1:0]        BRESP_S,
   output logic              BVALID_S,
   input  logic              BREADY_S,
   output logic              SRAM_CEB,
   output logic [3:0]        SRAM_WEB,
   output logic [MEM_AW-1:0] SRAM_A,
   output logic [DATA_W-1:0] SRAM_DI,
   input  logic [DATA_W-1:0] SRAM_DO
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     id_q;
   logic [MEM_AW-1:0]   addr_q;
   logic [3:0]          len_q;
   logic [3:0]          beat_q;
   logic                err_q;
   logic                rd_first_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ar_hs, aw_hs, r_hs, w_hs;
   logic                last;
   logic                ar_err, aw_err;
   logic                sram_rd, sram_wr;
   logic                unused_ok;

`ifdef AXI_SLAVE_DECERR_EN
   assign ar_err = |ARADDR_S[ADDR_W-1:MEM_AW+2];
   assign aw_err = |AWADDR_S[ADDR_W-1:MEM_AW+2];
`else
   assign ar_err = 1'b0;
   assign aw_err = 1'b0;
`endif

   // Size/burst are fixed by the system (4-byte INCR) and the beat count ends a write, not WLAST.
   assign unused_ok = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S, WLAST_S, ARADDR_S, AWADDR_S};

   assign last = (beat_q == len_q);

   always_comb begin
      state_d = state_q;
      ar_hs   = 1'b0;
      aw_hs   = 1'b0;
      r_hs    = 1'b0;
      w_hs    = 1'b0;
      case (state_q)
         IDLE: begin
            if (ARVALID_S) begin
               ar_hs   = 1'b1;
               state_d = RD_REQ;
            end else if (AWVALID_S) begin
               aw_hs   = 1'b1;
               state_d = WR_DATA;
            end
         end
         RD_REQ:  state_d = RD_DATA;
         RD_DATA: begin
            if (RREADY_S) begin
               r_hs    = 1'b1;
               state_d = last ? IDLE : RD_REQ;
            end
         end
         WR_DATA: begin
            if (WVALID_S) begin
               w_hs = 1'b1;
               if (last) state_d = WR_RESP;
            end
         end
         WR_RESP: if (BREADY_S) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         rd_first_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rd_first_q <= (state_q == RD_REQ);
         // SRAM_DO is only guaranteed in the first data cycle; hold it for back-pressure.
         if (rd_first_q) rdata_q <= SRAM_DO;
         if (ar_hs) begin
            id_q   <= ARID_S;
            addr_q <= ARADDR_S[MEM_AW+1:2];
            len_q  <= ARLEN_S;
            beat_q <= '0;
            err_q  <= ar_err;
         end else if (aw_hs) begin
            id_q   <= AWID_S;
            addr_q <= AWADDR_S[MEM_AW+1:2];
            len_q  <= AWLEN_S;
            beat_q <= '0;
            err_q  <= aw_err;
         end else if ((r_hs || w_hs) && !last) begin
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 1'b1;
         end
      end
   end

   // Outputs are qualified with rst_n so nothing is requested or written while reset is low.
   assign sram_rd = (state_q == RD_REQ) && !err_q;
   assign sram_wr = w_hs && !err_q;

   assign ARREADY_S = rst_n && (state_q == IDLE);
   assign AWREADY_S = rst_n && (state_q == IDLE) && !ARVALID_S;
   assign WREADY_S  = rst_n && (state_q == WR_DATA);
   assign RVALID_S  = rst_n && (state_q == RD_DATA);
   assign RLAST_S   = RVALID_S && last;
   assign RRESP_S   = (RVALID_S && err_q) ? 2'b11 : 2'b00;
   assign RDATA_S   = (RVALID_S && !err_q) ? (rd_first_q ? SRAM_DO : rdata_q) : '0;
   assign RID_S     = id_q;
   assign BVALID_S  = rst_n && (state_q == WR_RESP);
   assign BRESP_S   = (BVALID_S && err_q) ? 2'b11 : 2'b00;
   assign BID_S     = id_q;

   assign SRAM_CEB = !(rst_n && (sram_rd || sram_wr));
   assign SRAM_WEB = (rst_n && sram_wr) ? WSTRB_S : 4'hF;
   assign SRAM_A   = addr_q;
   assign SRAM_DI  = WDATA_S;

endmodule
